// File: rtl/serial_tx_if.sv
// Byte-sink handshake between a client (master) and the UART transmitter (slave).
// The serial line and the flow-control input travel with the bundle.
interface serial_tx_if;
    logic       tx;
    logic       block;
    logic       busy;
    logic [7:0] data;
    logic       new_data;

    modport master (output block, data, new_data, input tx, busy);
    modport slave  (input block, data, new_data, output tx, busy);
endinterface

// File: rtl/serial_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A registered block input holds off new frames without cutting one short.
module serial_tx #(
    parameter int unsigned CLK_PER_BIT = 50,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    serial_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          block_q;
    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic          bit_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            block_q <= 1'b0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            block_q <= bus.block;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        bit_done = (baud_q == BAUD_LAST);

        if (state_q != IDLE) begin
            baud_d = bit_done ? '0 : baud_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.new_data && !busy_q) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = bus.data;
                    par_d   = (PARITY == 1) ? ~^bus.data : ^bus.data;
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                        bit_d   = '0;
                    end
                end
            end
            PAR: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx and busy are computed from the next state so both flops change with the state register
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PAR:     tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || block_q;
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at 4 clocks per bit: default framing, odd/even parity,
// two stop bits, ignored strobes, back-to-back frames, block flow control and mid-frame reset.
module tb_serial_tx;
    logic       clk;
    logic       rst;
    logic [7:0] tbData;
    logic       tbNew;
    logic       tbBlock;
    logic [3:0] txAll;
    logic [3:0] busyAll;
    int         testsRun;
    int         failures;
    int         busyHighCount;

    serial_tx_if if0 ();
    serial_tx_if if1 ();
    serial_tx_if if2 ();
    serial_tx_if if3 ();

    assign if0.data = tbData;  assign if0.new_data = tbNew;  assign if0.block = tbBlock;
    assign if1.data = tbData;  assign if1.new_data = tbNew;  assign if1.block = tbBlock;
    assign if2.data = tbData;  assign if2.new_data = tbNew;  assign if2.block = tbBlock;
    assign if3.data = tbData;  assign if3.new_data = tbNew;  assign if3.block = tbBlock;

    assign txAll   = {if3.tx, if2.tx, if1.tx, if0.tx};
    assign busyAll = {if3.busy, if2.busy, if1.busy, if0.busy};

    serial_tx #(.CLK_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    serial_tx #(.CLK_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_tx #(.CLK_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    serial_tx #(.CLK_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; strobes new_data for exactly one cycle.
    task automatic applyStimulus(input logic [7:0] b);
        tbData = b;
        tbNew  = 1'b1;
        @(negedge clk);
        tbNew  = 1'b0;
    endtask

    task automatic idleGap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at the falling edge of the first expected start-bit cycle; expBits[0] goes out first.
    task automatic checkOutput(input int k, input string tag, input int nBits, input logic [11:0] expBits,
                               input int strobeCycle, input logic [7:0] strobeByte, input int blockCycle);
        int cyc = 0;
        int busyLow = 0;
        for (int b = 0; b < nBits; b++) begin
            logic [3:0] got;
            logic [3:0] want;
            for (int c = 0; c < 4; c++) begin
                got[c] = txAll[k];
                if (busyAll[k] !== 1'b1) busyLow++;
                else busyHighCount++;
                if (cyc == strobeCycle) begin
                    tbData = strobeByte;
                    tbNew  = 1'b1;
                end else begin
                    tbNew  = 1'b0;
                end
                if (cyc == blockCycle) tbBlock = 1'b1;
                cyc++;
                @(negedge clk);
            end
            want = {4{expBits[b]}};
            testsRun++;
            assert (got === want) else begin
                failures++;
                $error("FAIL %s bit%0d tx observed=%b expected=%b", tag, b, got, want);
            end
        end
        tbNew = 1'b0;
        testsRun++;
        assert (busyLow === 0) else begin
            failures++;
            $error("FAIL %s busy_in_frame low_cycles observed=%0d expected=0", tag, busyLow);
        end
        testsRun++;
        assert (txAll[k] === 1'b1) else begin
            failures++;
            $error("FAIL %s tx_after_frame observed=%b expected=1", tag, txAll[k]);
        end
        testsRun++;
        assert (busyAll[k] === tbBlock) else begin
            failures++;
            $error("FAIL %s busy_after_frame observed=%b expected=%b", tag, busyAll[k], tbBlock);
        end
    endtask

    // Watches the default instance for n cycles and reports how many cycles tx was low / busy high.
    task automatic watchLine(input int n, output int txLow, output int busyHigh);
        txLow = 0;
        busyHigh = 0;
        for (int i = 0; i < n; i++) begin
            if (txAll[0] !== 1'b1) txLow++;
            if (busyAll[0] !== 1'b0) busyHigh++;
            @(negedge clk);
        end
    endtask

    initial begin
        int txLow;
        int busyHigh;
        int waited;

        testsRun      = 0;
        failures      = 0;
        busyHighCount = 0;
        rst     = 1'b1;
        tbData  = 8'h00;
        tbNew   = 1'b0;
        tbBlock = 1'b0;

        repeat (3) @(negedge clk);
        testsRun++;
        assert (txAll === 4'hF) else begin
            failures++;
            $error("FAIL reset_tx observed=%b expected=1111", txAll);
        end
        testsRun++;
        assert (busyAll === 4'h0) else begin
            failures++;
            $error("FAIL reset_busy observed=%b expected=0000", busyAll);
        end
        rst = 1'b0;
        idleGap(3);

        $display("[TB] 0x55 default framing");
        applyStimulus(8'h55);
        checkOutput(0, "b55", 10, 12'b001010101010, -1, 8'h00, -1);

        $display("[TB] parity and stop-bit variants with 0x07");
        idleGap(8);
        applyStimulus(8'h07);
        checkOutput(1, "even07", 11, 12'b011000001110, -1, 8'h00, -1);
        idleGap(8);
        applyStimulus(8'h07);
        checkOutput(2, "odd07", 11, 12'b010000001110, -1, 8'h00, -1);
        idleGap(8);
        applyStimulus(8'h07);
        checkOutput(3, "stop2", 11, 12'b011000001110, -1, 8'h00, -1);

        $display("[TB] strobe while busy is dropped");
        idleGap(8);
        applyStimulus(8'hA3);
        checkOutput(0, "bA3", 10, 12'b001101000110, 10, 8'hFF, -1);
        watchLine(60, txLow, busyHigh);
        testsRun++;
        assert (txLow === 0) else begin
            failures++;
            $error("FAIL dropped_strobe tx_low_cycles observed=%0d expected=0", txLow);
        end

        $display("[TB] back-to-back frames");
        idleGap(8);
        busyHighCount = 0;
        applyStimulus(8'h01);
        checkOutput(0, "b2b01", 10, 12'b001000000010, -1, 8'h00, -1);
        applyStimulus(8'h80);
        checkOutput(0, "b2b80", 10, 12'b001100000000, -1, 8'h00, -1);
        testsRun++;
        assert (busyHighCount === 80) else begin
            failures++;
            $error("FAIL b2b busy_cycles observed=%0d expected=80", busyHighCount);
        end

        $display("[TB] block raised mid-frame");
        idleGap(8);
        applyStimulus(8'h55);
        checkOutput(0, "blk55", 10, 12'b001010101010, -1, 8'h00, 8);
        applyStimulus(8'h00);
        watchLine(20, txLow, busyHigh);
        testsRun++;
        assert (txLow === 0) else begin
            failures++;
            $error("FAIL blocked_strobe tx_low_cycles observed=%0d expected=0", txLow);
        end
        testsRun++;
        assert (busyHigh === 20) else begin
            failures++;
            $error("FAIL blocked_busy high_cycles observed=%0d expected=20", busyHigh);
        end
        tbBlock = 1'b0;
        waited = 0;
        while (busyAll[0] !== 1'b0 && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        testsRun++;
        assert (waited === 2) else begin
            failures++;
            $error("FAIL unblock_busy cycles_to_low observed=%0d expected=2", waited);
        end
        applyStimulus(8'h55);
        checkOutput(0, "unblk55", 10, 12'b001010101010, -1, 8'h00, -1);

        $display("[TB] reset during data bit 3");
        idleGap(8);
        applyStimulus(8'h00);
        repeat (17) @(negedge clk);
        testsRun++;
        assert (txAll[0] === 1'b0) else begin
            failures++;
            $error("FAIL pre_reset_tx observed=%b expected=0", txAll[0]);
        end
        #2 rst = 1'b1;
        #1;
        testsRun++;
        assert (txAll[0] === 1'b1) else begin
            failures++;
            $error("FAIL async_reset_tx observed=%b expected=1", txAll[0]);
        end
        testsRun++;
        assert (busyAll[0] === 1'b0) else begin
            failures++;
            $error("FAIL async_reset_busy observed=%b expected=0", busyAll[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        watchLine(10, txLow, busyHigh);
        testsRun++;
        assert (txLow === 0 && busyHigh === 0) else begin
            failures++;
            $error("FAIL post_reset_quiet observed tx_low=%0d busy_high=%0d expected 0 and 0", txLow, busyHigh);
        end
        applyStimulus(8'h3C);
        checkOutput(0, "b3C", 10, 12'b001001111000, -1, 8'h00, -1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end
endmodule
